// File: rtl/round_arbiter_pkg.sv
// Shared FPU definitions: rounding-mode encodings and default significand width.
package round_arbiter_pkg;

    localparam int unsigned SIG_W_DEF = 53;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

endpackage

// File: rtl/round_arbiter_core.sv
// Combinational rounding datapath: decides the increment from round/sticky/sign/rm
// and applies it to the significand at bit 0.
module round_core
    import round_arbiter_pkg::*;
#(
    parameter int unsigned SIG_W = SIG_W_DEF
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic             i_round,
    input  logic             i_sticky,
    input  logic             i_sign,
    input  logic [2:0]       i_rm,
    output logic [SIG_W-1:0] o_sig,
    output logic             o_inexact,
    output logic             o_cout,
    output logic             o_rup,
    output logic             o_bad_rm
);

    logic w_inexact;
    logic w_rup;
    logic w_bad_rm;

    always_comb begin
        w_inexact = i_round | i_sticky;
        w_rup     = 1'b0;
        w_bad_rm  = 1'b0;
        case (i_rm)
            RM_RNE:  w_rup = i_round & (i_sticky | i_sig[0]);
            RM_RTZ:  w_rup = 1'b0;
            RM_RDN:  w_rup = w_inexact & i_sign;
            RM_RUP:  w_rup = w_inexact & ~i_sign;
            RM_RMM:  w_rup = i_round;
            default: w_bad_rm = 1'b1;
        endcase
    end

    // Carry out only occurs when the increment rolls an all-ones significand to zero.
    assign o_sig     = i_sig + SIG_W'(w_rup);
    assign o_cout    = w_rup & (&i_sig);
    assign o_inexact = w_inexact;
    assign o_rup     = w_rup;
    assign o_bad_rm  = w_bad_rm;

endmodule

// File: rtl/round_arbiter.sv
// Two-requester round-robin front end sharing one round_core, with a single
// registered output stage that may drain and refill in the same cycle.
module round_arbiter
    import round_arbiter_pkg::*;
#(
    parameter int unsigned SIG_W = SIG_W_DEF,
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            io_in_valid,
    output logic [1:0]            io_in_ready,
    input  logic [1:0][SIG_W-1:0] io_in_sig,
    input  logic [1:0]            io_in_round,
    input  logic [1:0]            io_in_sticky,
    input  logic [1:0]            io_in_sign,
    input  logic [1:0][2:0]       io_in_rm,
    input  logic [1:0][TAG_W-1:0] io_in_tag,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [SIG_W-1:0]      io_out_sig,
    output logic                  io_out_inexact,
    output logic                  io_out_cout,
    output logic                  io_out_rup,
    output logic                  io_out_bad_rm,
    output logic                  io_out_src,
    output logic [TAG_W-1:0]      io_out_tag
);

    logic             r_valid;
    logic             r_last;
    logic [SIG_W-1:0] r_sig;
    logic             r_inexact;
    logic             r_cout;
    logic             r_rup;
    logic             r_bad_rm;
    logic             r_src;
    logic [TAG_W-1:0] r_tag;

    logic [1:0]       w_grant;
    logic             w_free;
    logic             w_xfer;
    logic             w_sel;
    logic [SIG_W-1:0] w_sig;
    logic             w_inexact;
    logic             w_cout;
    logic             w_rup;
    logic             w_bad_rm;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        if (&io_in_valid)
            w_grant = r_last ? 2'b01 : 2'b10;
        else
            w_grant = io_in_valid;
    end

    assign w_free      = ~r_valid | io_out_ready;
    assign io_in_ready = reset ? 2'b00 : (w_grant & {2{w_free}});
    assign w_xfer      = |io_in_ready;
    assign w_sel       = w_grant[1];

    round_core #(
        .SIG_W (SIG_W)
    ) u_core (
        .i_sig     (io_in_sig[w_sel]),
        .i_round   (io_in_round[w_sel]),
        .i_sticky  (io_in_sticky[w_sel]),
        .i_sign    (io_in_sign[w_sel]),
        .i_rm      (io_in_rm[w_sel]),
        .o_sig     (w_sig),
        .o_inexact (w_inexact),
        .o_cout    (w_cout),
        .o_rup     (w_rup),
        .o_bad_rm  (w_bad_rm)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_last    <= 1'b1;
            r_sig     <= '0;
            r_inexact <= 1'b0;
            r_cout    <= 1'b0;
            r_rup     <= 1'b0;
            r_bad_rm  <= 1'b0;
            r_src     <= 1'b0;
            r_tag     <= '0;
        end else if (w_xfer) begin
            r_valid   <= 1'b1;
            r_last    <= w_sel;
            r_sig     <= w_sig;
            r_inexact <= w_inexact;
            r_cout    <= w_cout;
            r_rup     <= w_rup;
            r_bad_rm  <= w_bad_rm;
            r_src     <= w_sel;
            r_tag     <= io_in_tag[w_sel];
        end else if (io_out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign io_out_valid   = r_valid;
    assign io_out_sig     = r_sig;
    assign io_out_inexact = r_inexact;
    assign io_out_cout    = r_cout;
    assign io_out_rup     = r_rup;
    assign io_out_bad_rm  = r_bad_rm;
    assign io_out_src     = r_src;
    assign io_out_tag     = r_tag;

endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level reference model.
module tb_round_arbiter;

    localparam int SW = 53;
    localparam int TW = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [1:0]          io_in_valid;
    logic [1:0]          io_in_ready;
    logic [1:0][SW-1:0]  io_in_sig;
    logic [1:0]          io_in_round;
    logic [1:0]          io_in_sticky;
    logic [1:0]          io_in_sign;
    logic [1:0][2:0]     io_in_rm;
    logic [1:0][TW-1:0]  io_in_tag;
    logic                io_out_valid;
    logic                io_out_ready;
    logic [SW-1:0]       io_out_sig;
    logic                io_out_inexact;
    logic                io_out_cout;
    logic                io_out_rup;
    logic                io_out_bad_rm;
    logic                io_out_src;
    logic [TW-1:0]       io_out_tag;

    round_arbiter #(
        .SIG_W (SW),
        .TAG_W (TW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_valid    (io_in_valid),
        .io_in_ready    (io_in_ready),
        .io_in_sig      (io_in_sig),
        .io_in_round    (io_in_round),
        .io_in_sticky   (io_in_sticky),
        .io_in_sign     (io_in_sign),
        .io_in_rm       (io_in_rm),
        .io_in_tag      (io_in_tag),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_sig     (io_out_sig),
        .io_out_inexact (io_out_inexact),
        .io_out_cout    (io_out_cout),
        .io_out_rup     (io_out_rup),
        .io_out_bad_rm  (io_out_bad_rm),
        .io_out_src     (io_out_src),
        .io_out_tag     (io_out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [SW-1:0] sig;
        logic          rnd;
        logic          stk;
        logic          sgn;
        logic [2:0]    rm;
        logic [TW-1:0] tag;
    } req_t;

    typedef struct {
        logic          valid;
        logic [SW-1:0] sig;
        logic          inexact;
        logic          cout;
        logic          rup;
        logic          bad_rm;
        logic          src;
        logic [TW-1:0] tag;
    } res_t;

    req_t pend [2];
    bit   pv   [2];
    bit   m_last;
    res_t m_out;
    int   errors = 0;
    int   checks = 0;

    // Reference rounding: classify the discarded fraction relative to one half.
    function automatic res_t ref_round(input req_t r, input bit src);
        res_t        o;
        int          frac;
        bit          up;
        logic [SW:0] sum;
        frac = (r.rnd ? 2 : 0) + (r.stk ? 1 : 0);
        case (r.rm)
            3'd0:    up = (frac > 2) || (frac == 2 && r.sig[0]);
            3'd1:    up = 1'b0;
            3'd2:    up = (frac != 0) && r.sgn;
            3'd3:    up = (frac != 0) && !r.sgn;
            3'd4:    up = (frac >= 2);
            default: up = 1'b0;
        endcase
        sum       = {1'b0, r.sig} + (up ? 1 : 0);
        o.valid   = 1'b1;
        o.sig     = sum[SW-1:0];
        o.cout    = sum[SW];
        o.rup     = up;
        o.inexact = (frac != 0);
        o.bad_rm  = (r.rm > 3'd4);
        o.src     = src;
        o.tag     = r.tag;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        io_in_valid = {pv[1], pv[0]};
        for (int i = 0; i < 2; i++) begin
            io_in_sig[i]    = pend[i].sig;
            io_in_round[i]  = pend[i].rnd;
            io_in_sticky[i] = pend[i].stk;
            io_in_sign[i]   = pend[i].sgn;
            io_in_rm[i]     = pend[i].rm;
            io_in_tag[i]    = pend[i].tag;
        end
    endtask

    task automatic check_out();
        chk("out_valid",   64'(io_out_valid),   64'(m_out.valid));
        chk("out_sig",     64'(io_out_sig),     64'(m_out.sig));
        chk("out_inexact", 64'(io_out_inexact), 64'(m_out.inexact));
        chk("out_cout",    64'(io_out_cout),    64'(m_out.cout));
        chk("out_rup",     64'(io_out_rup),     64'(m_out.rup));
        chk("out_bad_rm",  64'(io_out_bad_rm),  64'(m_out.bad_rm));
        chk("out_src",     64'(io_out_src),     64'(m_out.src));
        chk("out_tag",     64'(io_out_tag),     64'(m_out.tag));
    endtask

    task automatic post(input int i, input logic [SW-1:0] sig, input bit rnd, input bit stk,
                        input bit sgn, input logic [2:0] rm, input logic [TW-1:0] tag);
        pend[i].sig = sig;
        pend[i].rnd = rnd;
        pend[i].stk = stk;
        pend[i].sgn = sgn;
        pend[i].rm  = rm;
        pend[i].tag = tag;
        pv[i]       = 1'b1;
    endtask

    task automatic post_rand(input int i);
        logic [SW-1:0] s;
        s = SW'({$urandom(), $urandom()});
        case ($urandom_range(0, 7))
            0: s = '1;
            1: s = SW'($urandom_range(0, 3));
            default: ;
        endcase
        post(i, s, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
             TW'($urandom));
    endtask

    // One clock cycle: drive, check ready before the edge, update model, check outputs after.
    task automatic step(input bit ordy);
        logic [1:0] eg;
        bit         free;
        bit         g;
        io_out_ready = ordy;
        drive();
        #1;
        free = !m_out.valid || ordy;
        if (pv[0] && pv[1]) eg = m_last ? 2'b01 : 2'b10;
        else                eg = {pv[1], pv[0]};
        if (!free) eg = 2'b00;
        chk("in_ready", 64'(io_in_ready), 64'(eg));
        @(posedge clock);
        if (eg != 2'b00) begin
            g      = eg[1];
            m_out  = ref_round(pend[g], g);
            m_last = g;
            pv[g]  = 1'b0;
        end else if (ordy) begin
            m_out.valid = 1'b0;
        end
        #1;
        check_out();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        io_out_ready = 1'b1;
        drive();
        #1;
        chk("in_ready_reset", 64'(io_in_ready), 64'd0);
        @(posedge clock);
        m_out  = '{default: '0};
        m_last = 1'b1;
        #1;
        check_out();
        reset = 1'b0;
    endtask

    task automatic flush();
        for (int k = 0; k < 8 && (pv[0] || pv[1] || m_out.valid); k++) step(1'b1);
        chk("flush_done", 64'(pv[0] || pv[1] || m_out.valid), 64'd0);
    endtask

    initial begin
        logic [SW-1:0] ones;
        res_t          held;
        ones = '1;
        reset = 1'b1;
        io_out_ready = 1'b0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        pend[0] = '{default: '0};
        pend[1] = '{default: '0};
        m_out = '{default: '0};
        m_last = 1'b1;
        drive();
        @(posedge clock);
        #1;
        do_reset();

        // Single request, RNE halfway on odd significand rounds up.
        post(0, SW'(1), 1'b1, 1'b0, 1'b0, 3'd0, 4'h3);
        step(1'b1);
        chk("r032_sig", 64'(io_out_sig), 64'h2);
        chk("r032_rup", 64'(io_out_rup), 64'd1);
        flush();

        // Continuous tie after reset alternates 0,1,0,1.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (!pv[0]) post_rand(0);
            if (!pv[1]) post_rand(1);
            step(1'b1);
            chk("alt_src", 64'(io_out_src), 64'(k % 2));
        end
        flush();

        // All-ones significand rounding up wraps with carry out.
        post(1, ones, 1'b0, 1'b1, 1'b0, 3'd3, 4'hA);
        step(1'b1);
        chk("r034_sig",  64'(io_out_sig),  64'd0);
        chk("r034_cout", 64'(io_out_cout), 64'd1);
        chk("r034_tag",  64'(io_out_tag),  64'hA);
        flush();

        // Stall with both requesting: nothing accepted, output held; then drain and refill.
        post_rand(0);
        post_rand(1);
        step(1'b1);
        held = m_out;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            chk("stall_ready", 64'(io_in_ready), 64'd0);
            chk("stall_sig",   64'(io_out_sig),  64'(held.sig));
        end
        step(1'b1);
        chk("refill_valid", 64'(io_out_valid), 64'd1);
        chk("refill_src",   64'(io_out_src),   64'(!held.src));
        flush();

        // Illegal rounding mode: no increment, flagged.
        post(0, SW'(5), 1'b1, 1'b0, 1'b0, 3'd6, 4'h1);
        step(1'b1);
        chk("r036_sig",    64'(io_out_sig),    64'h5);
        chk("r036_bad_rm", 64'(io_out_bad_rm), 64'd1);
        flush();

        // Reset while holding a result discards it; next tie goes to requester 0.
        post_rand(1);
        step(1'b0);
        post_rand(0);
        post_rand(1);
        do_reset();
        chk("r037_valid", 64'(io_out_valid), 64'd0);
        step(1'b1);
        chk("r037_src", 64'(io_out_src), 64'd0);
        flush();

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(0, 2) != 0) post_rand(i);
            step($urandom_range(0, 3) != 0);
        end
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 Parameter SIG_W, default 53, significand width handled (rounding position is bit 0).
REQ-002 Parameter TAG_W, default 4, width of requester-supplied tag passed through unchanged.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_in_valid  input  2  per-requester request valid (index 0 = requester 0).
REQ-006 io_in_ready  output  2  per-requester accept; request transfers when valid and ready are both high.
REQ-007 io_in_sig  input  2xSIG_W  per-requester unrounded significand.
REQ-008 io_in_round, io_in_sticky, io_in_sign  input  2 each  per-requester round bit, sticky bit, result sign.
REQ-009 io_in_rm  input  2x3  per-requester rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM).
REQ-010 io_in_tag  input  2xTAG_W  per-requester tag.
REQ-011 io_out_valid  output  1  result register holds a valid result.
REQ-012 io_out_ready  input  1  consumer accepts result.
REQ-013 io_out_sig  output  SIG_W  rounded significand (modulo 2^SIG_W).
REQ-014 io_out_inexact, io_out_cout, io_out_rup, io_out_bad_rm  output  1 each  inexact flag, carry out of rounding increment, increment applied, rm was 5..7.
REQ-015 io_out_src  output  1  index of requester that produced the result; io_out_tag  output  TAG_W  its tag.

Function
REQ-016 Block SHALL share one rounding datapath between two requesters with round-robin arbitration and a single registered output stage.
REQ-017 Stage free = !io_out_valid | io_out_ready (same-cycle drain-and-refill allowed).
REQ-018 Grant: if only one valid, grant it; if both valid, grant requester != last_grant; last_grant is 1-bit state.
REQ-019 io_in_ready[i] SHALL equal grant[i] & stage-free; at most one bit of io_in_ready high per cycle.
REQ-020 On transfer, last_grant SHALL update to granted index; no update without transfer.
REQ-021 Rounding of granted request: inexact = round|sticky; rup: RNE round&(sticky|sig[0]); RTZ 0; RDN inexact&sign; RUP inexact&!sign; RMM round; rm 5..7: rup=0, bad_rm=1.
REQ-022 out_sig = rup ? sig+1 : sig (SIG_W bits, wraps); cout = rup & (sig all ones).
REQ-023 Latency: result SHALL appear on io_out_* exactly one cycle after input transfer.
REQ-024 While io_out_valid & !io_out_ready, all io_out_* SHALL hold stable.
REQ-025 io_out_valid SHALL clear after output transfer unless a new input transfers in the same cycle.
REQ-026 Requesters SHALL keep valid and payload stable until transfer; block is not required to tolerate otherwise.
REQ-027 Output payload registers SHALL load only on input transfer.

Reset
REQ-028 During reset: io_out_valid=0, last_grant=1 (requester 0 wins first tie), all io_out_* payload registers 0.
REQ-029 Reset mid-operation SHALL discard held result; io_in_ready SHALL be 0 in the reset cycle.

Structure
REQ-030 Rounding-mode encodings (RNE..RMM) and SIG_W default SHALL live in the shared FPU package.
REQ-031 Rounding datapath SHALL be a combinational sub-module round_core (sig, round, sticky, sign, rm -> sig, inexact, cout, rup, bad_rm); arbitration and output register in round_arbiter.

Verification
REQ-032 Req0 only: sig=0x1, round=1, sticky=0, rm=0 -> next cycle out_sig=0x2, rup=1, inexact=1, cout=0, src=0.
REQ-033 Both valid continuously after reset, io_out_ready=1 -> transfers alternate src 0,1,0,1 one per cycle.
REQ-034 Req1: sig=all ones, sticky=1, sign=0, rm=3 -> out_sig=0, cout=1, rup=1, src=1, tag echoed.
REQ-035 io_out_valid=1, io_out_ready=0 for 3 cycles, both requests valid -> io_in_ready=00, outputs stable; ready=1 -> drain and refill same cycle.
REQ-036 rm=6, round=1, sig=0x5 -> out_sig=0x5, rup=0, bad_rm=1, inexact=1.
REQ-037 Reset asserted with io_out_valid=1 -> next cycle io_out_valid=0; subsequent tie grants requester 0.
